// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the clock-divider controller.
package clkdiv_pkg;

    localparam int unsigned NchDefault = 4;
    localparam int unsigned CwDefault  = 16;

    typedef enum logic {StIdle, StWait} state_e;

endpackage

// File: rtl/clkdiv_if.sv
// Configuration write handshake between a requester and clkdiv_ctrl.
interface clkdiv_if
    import clkdiv_pkg::*;
#(
    parameter int unsigned NCH = NchDefault,
    parameter int unsigned CW  = CwDefault
);
    localparam int unsigned ChW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_valid;
    logic           cfg_ready;
    logic [ChW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_en;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, output cfg_en,
                    input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, input cfg_en,
                    output cfg_ready);

endinterface

// File: rtl/clkdiv_chan.sv
// One divided-clock channel: half-period counter, toggle flop and load port.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned CW = CwDefault
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_div_i,
    input  logic          load_en_i,
    output logic          term_o,
    output logic          dclk_o,
    output logic          en_o
);

    logic [CW-1:0] d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          dclk_q, dclk_d;

    always_comb begin
        term_o = en_q && (cnt_q == d_q - CW'(1));
        d_d    = d_q;
        en_d   = en_q;
        cnt_d  = cnt_q;
        dclk_d = dclk_q;
        if (load_i) begin
            // A load on a running channel coincides with its terminal count, so the
            // toggle is still taken; a disable is only issued on the falling toggle.
            d_d    = load_div_i;
            en_d   = load_en_i;
            cnt_d  = '0;
            dclk_d = load_en_i & (dclk_q ^ term_o);
        end else if (en_q) begin
            if (term_o) begin
                cnt_d  = '0;
                dclk_d = ~dclk_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d  = '0;
            dclk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= CW'(1);
            en_q   <= 1'b0;
            cnt_q  <= '0;
            dclk_q <= 1'b0;
        end else begin
            d_q    <= d_d;
            en_q   <= en_d;
            cnt_q  <= cnt_d;
            dclk_q <= dclk_d;
        end
    end

    assign dclk_o = dclk_q;
    assign en_o   = en_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Multi-channel clock divider: write FSM with glitch-free deferred reconfiguration.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned NCH = NchDefault,
    parameter int unsigned CW  = CwDefault
) (
    input  logic           clk,
    input  logic           rst,
    clkdiv_if.slave        cfg,
    output logic [NCH-1:0] dclk,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] ch_en
);

    localparam int unsigned ChW = (NCH > 1) ? $clog2(NCH) : 1;

    state_e         state_q, state_d;
    logic [ChW-1:0] pend_ch_q, pend_ch_d;
    logic [CW-1:0]  pend_div_q, pend_div_d;
    logic           pend_en_q, pend_en_d;

    logic [NCH-1:0] load;
    logic [CW-1:0]  load_div;
    logic           load_en;
    logic [CW-1:0]  cfg_div_eff;
    logic           accept;
    logic           ch_ok;

    assign cfg.cfg_ready = (state_q == StIdle) && !rst;

    always_comb begin
        cfg_div_eff = (cfg.cfg_div == '0) ? CW'(1) : cfg.cfg_div;
        accept      = cfg.cfg_valid && cfg.cfg_ready;
        ch_ok       = 32'(cfg.cfg_ch) < NCH;
        state_d     = state_q;
        pend_ch_d   = pend_ch_q;
        pend_div_d  = pend_div_q;
        pend_en_d   = pend_en_q;
        load        = '0;
        load_div    = pend_div_q;
        load_en     = pend_en_q;
        unique case (state_q)
            StIdle: begin
                if (accept && ch_ok) begin
                    if (ch_en[cfg.cfg_ch]) begin
                        state_d    = StWait;
                        pend_ch_d  = cfg.cfg_ch;
                        pend_div_d = cfg_div_eff;
                        pend_en_d  = cfg.cfg_en;
                    end else begin
                        load[cfg.cfg_ch] = 1'b1;
                        load_div         = cfg_div_eff;
                        load_en          = cfg.cfg_en;
                    end
                end
            end
            StWait: begin
                // Disables wait for a falling toggle so the high phase is never cut short.
                if (tick[pend_ch_q] && (pend_en_q || dclk[pend_ch_q])) begin
                    load[pend_ch_q] = 1'b1;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pend_ch_q  <= '0;
            pend_div_q <= CW'(1);
            pend_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_ch_q  <= pend_ch_d;
            pend_div_q <= pend_div_d;
            pend_en_q  <= pend_en_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clkdiv_chan #(
            .CW(CW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load_i    (load[i]),
            .load_div_i(load_div),
            .load_en_i (load_en),
            .term_o    (tick[i]),
            .dclk_o    (dclk[i]),
            .en_o      (ch_en[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Scoreboard bench for clkdiv_ctrl against an event-time reference model.
module tb_clkdiv_ctrl;
    import clkdiv_pkg::*;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int CHW = 2;

    typedef struct packed {
        logic [NCH-1:0] dclk;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] en;
        logic           rdy;
    } obs_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] dclk, tick, ch_en;

    clkdiv_if #(.NCH(NCH), .CW(CW)) cfg ();

    clkdiv_ctrl #(
        .NCH(NCH),
        .CW (CW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cfg  (cfg),
        .dclk (dclk),
        .tick (tick),
        .ch_en(ch_en)
    );

    always #5 clk = ~clk;

    // Reference model: each channel is described by its level and the absolute edge
    // index of its next toggle; n is the index of the upcoming clock edge.
    int   n = 0;
    bit   have_state = 0;
    bit   m_en[NCH];
    bit   m_lvl[NCH];
    int   m_d[NCH];
    int   m_nt[NCH];
    bit   m_wait;
    int   p_ch, p_div;
    bit   p_en;
    bit   accepted;
    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic model_edge();
        bit tog[NCH];
        bit was_wait;
        int ch, d;
        accepted = 0;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_lvl[c] = 0; m_d[c] = 1; m_nt[c] = 0;
            end
            m_wait = 0;
            have_state = 1;
        end else if (have_state) begin
            was_wait = m_wait;
            for (int c = 0; c < NCH; c++) tog[c] = m_en[c] && (m_nt[c] == n);
            if (m_wait && tog[p_ch] && (p_en || m_lvl[p_ch])) begin
                tog[p_ch] = 0;
                if (p_en) begin
                    m_lvl[p_ch] = !m_lvl[p_ch];
                    m_d[p_ch]   = p_div;
                    m_nt[p_ch]  = n + p_div;
                end else begin
                    m_lvl[p_ch] = 0;
                    m_en[p_ch]  = 0;
                end
                m_wait = 0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (tog[c]) begin
                    m_lvl[c] = !m_lvl[c];
                    m_nt[c]  = m_nt[c] + m_d[c];
                end
            end
            if (!was_wait && cfg.cfg_valid) begin
                accepted = 1;
                ch = int'(cfg.cfg_ch);
                d  = (cfg.cfg_div == 0) ? 1 : int'(cfg.cfg_div);
                if (!m_en[ch]) begin
                    m_en[ch]  = cfg.cfg_en;
                    m_d[ch]   = d;
                    m_lvl[ch] = 0;
                    m_nt[ch]  = n + d;
                end else begin
                    m_wait = 1;
                    p_ch   = ch;
                    p_div  = d;
                    p_en   = cfg.cfg_en;
                end
            end
        end
        n++;
    endtask

    task automatic cycle(input bit r, input bit v, input int ch, input int div, input bit en);
        obs_t e;
        rst           = r;
        cfg.cfg_valid = v;
        cfg.cfg_ch    = CHW'(ch);
        cfg.cfg_div   = CW'(div);
        cfg.cfg_en    = en;
        if (have_state) begin
            for (int c = 0; c < NCH; c++) begin
                e.dclk[c] = m_lvl[c];
                e.tick[c] = m_en[c] && (m_nt[c] == n);
                e.en[c]   = m_en[c];
            end
            e.rdy = !m_wait && !r;
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic write_hold(input int ch, input int div, input bit en);
        int k = 0;
        do begin
            cycle(0, 1, ch, div, en);
            k++;
        end while (!accepted && k < 200);
        if (!accepted) begin
            miscompares++;
            $display("FAIL write_accept ch%0d: not accepted after %0d cycles, required within 200",
                     ch, k);
        end
        cycle(0, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a full observation every cycle; sample mid-cycle.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{dclk: dclk, tick: tick, en: ch_en, rdy: cfg.cfg_ready};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL obs t=%0t: dclk=%b tick=%b ch_en=%b ready=%b, required dclk=%b tick=%b ch_en=%b ready=%b",
                             $time, a.dclk, a.tick, a.en, a.rdy, e.dclk, e.tick, e.en, e.rdy);
                end
            end
        end
    end

    initial begin
        int k;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        idle(2);

        // ch0 div=3 immediate start
        write_hold(0, 3, 1);
        idle(20);

        // ch1 div=4, then reconfigure to div=2 while running
        write_hold(1, 4, 1);
        idle(9);
        write_hold(1, 2, 1);
        idle(20);

        // ch2 div=5, then disable while its clock is low
        write_hold(2, 5, 1);
        idle(7);
        k = 0;
        while (m_lvl[2] && k < 50) begin idle(1); k++; end
        write_hold(2, 5, 0);
        idle(25);

        // ch3 div=0 behaves as D=1
        write_hold(3, 0, 1);
        idle(10);

        // write to ch0 landing exactly on its terminal cycle
        k = 0;
        while (!(m_en[0] && m_nt[0] == n && !m_wait) && k < 50) begin idle(1); k++; end
        if (k >= 50) begin
            miscompares++;
            $display("FAIL terminal_align: ch0 terminal not reached in 50 cycles, required < 50");
        end
        write_hold(0, 2, 1);
        idle(20);

        // reset while a pending write is outstanding
        write_hold(1, 7, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        idle(10);

        // randomized traffic, including writes dropped while not ready
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 6)),
                  $urandom_range(0, 99) < 85);
        end
        idle(2);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clkdiv_ctrl.md
CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of divided-clock channels (2..16).
REQ-002 Parameter CW, default 16: divisor/counter width in bits.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port cfg_valid  input  1  configuration write request.
REQ-006 Port cfg_ready  output  1  controller can accept a write; transfer occurs when cfg_valid & cfg_ready are both high at a clk edge.
REQ-007 Port cfg_ch  input  clog2(NCH)  target channel index.
REQ-008 Port cfg_div  input  CW  half-period in clk cycles.
REQ-009 Port cfg_en  input  1  target channel enable.
REQ-010 Port dclk  output  NCH  divided clocks, one bit per channel.
REQ-011 Port tick  output  NCH  one-cycle pulse coincident with each dclk toggle.
REQ-012 Port ch_en  output  NCH  currently applied enable per channel.

Function
REQ-013 Each channel SHALL hold an applied divisor D, an enable, and a counter 0..D-1; cfg_div=0 SHALL be stored as D=1.
REQ-014 An enabled channel SHALL increment its counter each cycle; at count D-1 (terminal) it SHALL toggle dclk, pulse tick for that cycle, and reset the counter to 0 (period 2*D cycles, 50% duty).
REQ-015 A disabled channel SHALL hold counter=0, dclk=0, tick=0.
REQ-016 Controller FSM states SHALL be IDLE and WAIT; cfg_ready=1 iff state=IDLE and rst=0.
REQ-017 A write accepted to a disabled channel SHALL update its D and enable at the accepting edge; state stays IDLE; if enabled, the first toggle occurs D cycles later.
REQ-018 A write accepted to an enabled channel SHALL be captured into a pending register and move the FSM to WAIT.
REQ-019 In WAIT with pending enable=1, the new D SHALL be loaded at the target's next terminal count (toggle still taken with old D); the counter restarts at 0 with the new D.
REQ-020 In WAIT with pending enable=0, the disable SHALL apply only at a terminal count where dclk goes 1->0; dclk then stays 0; no runt high pulse is permitted.
REQ-021 FSM SHALL return to IDLE the cycle after the pending write is applied; cfg_ready rises that cycle.
REQ-022 A terminal count occurring in the same cycle as acceptance SHALL NOT apply the pending write; only terminal counts observed in WAIT count.
REQ-023 Channels other than the target SHALL run undisturbed during IDLE and WAIT.
REQ-024 Writes while cfg_ready=0 SHALL be ignored (requester must hold cfg_valid).

Reset
REQ-025 While rst=1 at an edge: all channels disabled, D=1, counters 0, dclk=0, tick=0, ch_en=0, FSM=IDLE, pending cleared.
REQ-026 Reset asserted during WAIT SHALL discard the pending write; no partial update survives.
REQ-027 cfg_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.

Structure
REQ-028 Shared package clkdiv_pkg SHALL hold the FSM state enum and NCH/CW defaults.
REQ-029 Per-channel counter/toggle/load logic SHALL be a sub-module clkdiv_chan, instantiated NCH times; clkdiv_ctrl holds the FSM, pending register and load strobes.

Verification
REQ-030 After reset, write ch0 div=3 en=1 -> ch0 toggles every 3 cycles (period 6), tick each toggle, cfg_ready stays 1.
REQ-031 Ch1 running div=4; write div=2 -> cfg_ready=0 until next ch1 terminal; that toggle is 4 cycles after previous; subsequent toggles every 2; cfg_ready=1 one cycle after.
REQ-032 Ch2 running div=5 with dclk=0; write en=0 -> ch2 completes high half-period, falls, stays 0; ch_en[2] clears at the fall.
REQ-033 Write cfg_div=0 en=1 to ch3 -> ch3 toggles every cycle (D=1).
REQ-034 Assert rst during WAIT -> all dclk=0, ch_en=0, cfg_ready=0 during rst, 1 afterwards; pending write never applied.
REQ-035 Write accepted exactly on target terminal cycle -> applied at the following terminal, not the current one; other channels' periods unchanged throughout.
